// File: rtl/test_case_sequencer_if.sv
// Handshake bundle between the bench-side controller/checkers and the test case sequencer.
// master drives start/select and checker status; slave is the sequencer itself.
interface test_case_sequencer_if #(
  parameter int NUM_CASES = 8,
  parameter int CW        = 16,
  parameter int IW        = $clog2(NUM_CASES + 1)
);
  logic                 start;
  logic [IW-1:0]        case_sel;
  logic                 case_done;
  logic                 case_fail;
  logic                 dut_rst;
  logic [IW-1:0]        case_id;
  logic                 case_active;
  logic [CW-1:0]        cycles;
  logic                 case_end;
  logic                 case_pass;
  logic                 case_timeout;
  logic [NUM_CASES-1:0] pass_vec;
  logic [IW-1:0]        fail_count;
  logic                 all_done;
  logic                 bad_sel;

  modport master (
    output start, case_sel, case_done, case_fail,
    input  dut_rst, case_id, case_active, cycles, case_end, case_pass,
           case_timeout, pass_vec, fail_count, all_done, bad_sel
  );

  modport slave (
    input  start, case_sel, case_done, case_fail,
    output dut_rst, case_id, case_active, cycles, case_end, case_pass,
           case_timeout, pass_vec, fail_count, all_done, bad_sel
  );
endinterface

// File: rtl/test_case_sequencer.sv
// Sequences test cases 1..NUM_CASES: per-case DUT reset, timed RUN window,
// sticky failure capture and run-level pass vector / fail count.
module test_case_sequencer #(
  parameter int NUM_CASES  = 8,
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT    = 10000,
  parameter int CW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  test_case_sequencer_if.slave  bus
);
  localparam int IW = $clog2(NUM_CASES + 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NUM_CASES);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_NEXT, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        case_id;
  logic [CW-1:0]        cycles;
  logic [RW-1:0]        rst_cnt;
  logic                 fail_sticky;
  logic                 res_pass;
  logic                 res_timeout;
  logic                 sel_single;
  logic                 bad_sel;
  logic [NUM_CASES-1:0] pass_vec;
  logic [IW-1:0]        fail_count;

  logic sel_bad, last_case, run_end;

  assign sel_bad   = bus.case_sel > ID_LAST;
  assign last_case = sel_single || (case_id == ID_LAST);
  assign run_end   = bus.case_done || (cycles == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_nxt = sel_bad ? S_DONE : S_RESET;
      S_RESET:        if (rst_cnt == RST_LAST) state_nxt = S_RUN;
      S_RUN:          if (run_end) state_nxt = S_NEXT;
      S_NEXT:         state_nxt = last_case ? S_DONE : S_RESET;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      case_id     <= '0;
      cycles      <= '0;
      rst_cnt     <= '0;
      fail_sticky <= 1'b0;
      res_pass    <= 1'b0;
      res_timeout <= 1'b0;
      sel_single  <= 1'b0;
      bad_sel     <= 1'b0;
      pass_vec    <= '0;
      fail_count  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            pass_vec    <= '0;
            fail_count  <= '0;
            cycles      <= '0;
            rst_cnt     <= '0;
            fail_sticky <= 1'b0;
            res_pass    <= 1'b0;
            res_timeout <= 1'b0;
            bad_sel     <= sel_bad;
            sel_single  <= (bus.case_sel != '0);
            if (sel_bad)                 case_id <= '0;
            else if (bus.case_sel == '0) case_id <= IW'(1);
            else                         case_id <= bus.case_sel;
          end
        end
        S_RESET: begin
          rst_cnt     <= (rst_cnt == RST_LAST) ? '0 : rst_cnt + RW'(1);
          fail_sticky <= 1'b0;
          cycles      <= '0;
        end
        S_RUN: begin
          fail_sticky <= fail_sticky | bus.case_fail;
          // case_done takes precedence over a coincident timeout
          if (bus.case_done) begin
            res_pass    <= ~(fail_sticky | bus.case_fail);
            res_timeout <= 1'b0;
          end else if (cycles == CYC_LAST) begin
            res_pass    <= 1'b0;
            res_timeout <= 1'b1;
          end else begin
            cycles <= cycles + CW'(1);
          end
        end
        S_NEXT: begin
          if (res_pass) pass_vec   <= pass_vec | (NUM_CASES'(1) << (case_id - IW'(1)));
          else          fail_count <= fail_count + IW'(1);
          if (!last_case) begin
            case_id <= case_id + IW'(1);
            rst_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.dut_rst      = (state != S_RUN);
    bus.case_active  = (state == S_RUN);
    bus.case_end     = (state == S_NEXT);
    bus.case_pass    = (state == S_NEXT) && res_pass;
    bus.case_timeout = (state == S_NEXT) && res_timeout;
    bus.all_done     = (state == S_DONE);
    bus.case_id      = case_id;
    bus.cycles       = cycles;
    bus.pass_vec     = pass_vec;
    bus.fail_count   = fail_count;
    bus.bad_sel      = bad_sel;
  end
endmodule

// File: tb/tb_test_case_sequencer.sv
// Bench for test_case_sequencer: table-driven runs, randomized runs against a
// case-level result model, timeout edges and mid-run reset.
module tb_test_case_sequencer;
  localparam int NUM_CASES  = 8;
  localparam int RST_CYCLES = 3;
  localparam int TIMEOUT    = 10000;
  localparam int CW         = 16;
  localparam int IW         = $clog2(NUM_CASES + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  test_case_sequencer_if #(.NUM_CASES(NUM_CASES), .CW(CW), .IW(IW)) bus ();

  test_case_sequencer #(
    .NUM_CASES(NUM_CASES), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Checker behaviour per case: RUN cycle index of case_done / case_fail, -1 = never
  int done_at [1:NUM_CASES];
  int fail_at [1:NUM_CASES];

  typedef struct {
    int id;
    bit pass;
    bit to;
    int cyc;
  } end_t;
  end_t exp_q[$];

  int exp_pv, exp_fc, exp_steps, exp_runcyc;

  typedef struct {
    int   sel;
    int   done;
    int   fail;
    int   pv;
    int   fc;
    bit   bad;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    int id, c;
    logic [1:0] noise;
    @(posedge clk);
    #1;
    if (bus.case_active) begin
      id = int'(bus.case_id);
      c  = int'(bus.cycles);
      if (id >= 1 && id <= NUM_CASES) begin
        bus.case_done = (done_at[id] == c);
        bus.case_fail = (fail_at[id] == c);
      end else begin
        bus.case_done = 1'b0;
        bus.case_fail = 1'b0;
      end
    end else begin
      noise = 2'($urandom);
      bus.case_done = noise[0];
      bus.case_fail = noise[1];
    end
  endtask

  // Case-level model: which cases run, when each ends, and how it is scored.
  task automatic build_expect(input int sel);
    int first, last, d, f, cyc;
    bit pass, to;
    exp_q.delete();
    exp_pv = 0; exp_fc = 0; exp_steps = 1; exp_runcyc = 0;
    if (sel > NUM_CASES) return;
    first = (sel == 0) ? 1 : sel;
    last  = (sel == 0) ? NUM_CASES : sel;
    for (int k = first; k <= last; k++) begin
      d = done_at[k];
      f = fail_at[k];
      if (d >= 0 && d <= TIMEOUT - 1) begin
        to = 0; cyc = d; pass = !(f >= 0 && f <= d);
      end else begin
        to = 1; cyc = TIMEOUT - 1; pass = 0;
      end
      exp_q.push_back('{id: k, pass: pass, to: to, cyc: cyc});
      if (pass) exp_pv |= (1 << (k - 1));
      else      exp_fc++;
      exp_steps  += RST_CYCLES + cyc + 2;
      exp_runcyc += cyc + 1;
    end
  endtask

  task automatic run_seq(input int sel, input string tag);
    int n, first_act, rst_low, n_exp;
    end_t e;
    build_expect(sel);
    n_exp = exp_q.size();
    bus.start    = 1'b1;
    bus.case_sel = IW'(sel);
    step();
    bus.start    = 1'b0;
    bus.case_sel = IW'($urandom_range(0, 15));
    n = 1; first_act = -1; rst_low = 0;
    while (n <= exp_steps + 100) begin
      if (bus.case_active && first_act < 0) first_act = n;
      if (!bus.dut_rst) rst_low++;
      if (bus.case_end) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s.extra_case_end", tag), 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s.end_id", tag), bus.case_id, e.id);
          check($sformatf("%s.end_pass_c%0d", tag, e.id), bus.case_pass, e.pass);
          check($sformatf("%s.end_timeout_c%0d", tag, e.id), bus.case_timeout, e.to);
          check($sformatf("%s.end_cycles_c%0d", tag, e.id), bus.cycles, e.cyc);
        end
      end
      if (bus.all_done) break;
      step();
      n++;
    end
    check($sformatf("%s.all_done", tag), bus.all_done, 1);
    check($sformatf("%s.steps_to_done", tag), n, exp_steps);
    check($sformatf("%s.missing_case_ends", tag), exp_q.size(), 0);
    check($sformatf("%s.pass_vec", tag), bus.pass_vec, exp_pv);
    check($sformatf("%s.fail_count", tag), bus.fail_count, exp_fc);
    check($sformatf("%s.bad_sel", tag), bus.bad_sel, sel > NUM_CASES);
    check($sformatf("%s.dut_rst_low_cycles", tag), rst_low, exp_runcyc);
    if (n_exp > 0) check($sformatf("%s.start_latency", tag), first_act, RST_CYCLES + 1);
  endtask

  task automatic set_all(input int d, input int f);
    for (int k = 1; k <= NUM_CASES; k++) begin
      done_at[k] = d;
      fail_at[k] = f;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    tbl[0] = '{sel: 0, done: 4, fail: -1, pv: 'hFF, fc: 0, bad: 0};
    tbl[1] = '{sel: 3, done: 4, fail: 2,  pv: 'h00, fc: 1, bad: 0};
    tbl[2] = '{sel: 9, done: 4, fail: -1, pv: 'h00, fc: 0, bad: 1};
    tbl[3] = '{sel: 2, done: 0, fail: 0,  pv: 'h00, fc: 1, bad: 0};
    tbl[4] = '{sel: 8, done: 3, fail: 4,  pv: 'h80, fc: 0, bad: 0};
    tbl[5] = '{sel: 0, done: 1, fail: 1,  pv: 'h00, fc: 8, bad: 0};
    tbl[6] = '{sel: 5, done: 2, fail: -1, pv: 'h10, fc: 0, bad: 0};

    set_all(-1, -1);
    rst = 1'b1;
    bus.start = 1'b0; bus.case_sel = '0; bus.case_done = 1'b0; bus.case_fail = 1'b0;
    step(); step();
    check("reset.dut_rst", bus.dut_rst, 1);
    check("reset.case_id", bus.case_id, 0);
    check("reset.all_done", bus.all_done, 0);
    check("reset.pass_vec", bus.pass_vec, 0);
    check("reset.fail_count", bus.fail_count, 0);
    check("reset.case_active", bus.case_active, 0);
    check("reset.case_end", bus.case_end, 0);
    check("reset.bad_sel", bus.bad_sel, 0);
    check("reset.cycles", bus.cycles, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      set_all(tbl[i].done, tbl[i].fail);
      run_seq(tbl[i].sel, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.table_pass_vec", i), bus.pass_vec, tbl[i].pv);
      check($sformatf("tbl%0d.table_fail_count", i), bus.fail_count, tbl[i].fc);
      check($sformatf("tbl%0d.table_bad_sel", i), bus.bad_sel, tbl[i].bad);
    end

    for (int r = 0; r < 8; r++) begin
      for (int k = 1; k <= NUM_CASES; k++) begin
        done_at[k] = $urandom_range(0, 12);
        fail_at[k] = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 12));
      end
      run_seq($urandom_range(0, NUM_CASES + 1), $sformatf("rand%0d", r));
    end

    set_all(-1, -1);
    run_seq(1, "timeout");
    done_at[1] = TIMEOUT - 1;
    run_seq(1, "done_at_limit");
    done_at[1] = -1;
    fail_at[1] = TIMEOUT - 1;
    run_seq(1, "fail_at_limit");

    // Reset while case 4 of a run-all is in RUN
    set_all(4, -1);
    fail_at[2] = 1;
    bus.start = 1'b1; bus.case_sel = '0;
    step();
    bus.start = 1'b0;
    guard = 0;
    while (!(bus.case_active && bus.case_id == IW'(4)) && guard < 200) begin
      step();
      guard++;
    end
    check("midrst.reached_case4", guard < 200, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.dut_rst", bus.dut_rst, 1);
    check("midrst.case_id", bus.case_id, 0);
    check("midrst.case_active", bus.case_active, 0);
    check("midrst.all_done", bus.all_done, 0);
    check("midrst.pass_vec", bus.pass_vec, 0);
    check("midrst.fail_count", bus.fail_count, 0);
    check("midrst.cycles", bus.cycles, 0);
    step();
    check("midrst.idle_holds", bus.dut_rst && !bus.case_active && !bus.all_done, 1);
    set_all(4, -1);
    run_seq(0, "after_midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
